mips_cpu: RTL and testbench

- Five-stage in-order pipelined MIPS-subset processor: IF, ID, EX, MEM, WB.
- Instruction memory, register file and data memory are internal to the block.
- No hazard detection, forwarding or flush logic: software schedules around all hazards with NOP padding.
- Top-level processor block of the design; its only ports are clock and reset.

---
 rtl/mips_cpu.sv | 205 ++++++++++++++++++++
 tb/tb_mips_cpu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with internal instruction,
// register and data storage; no interlocks, software pads all hazards.

module fetch #(
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_take_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);
  localparam int unsigned IW = $clog2(IMEM_WORDS);

  logic [31:0] instruction [IMEM_WORDS];
  logic [31:0] PC;

  always_ff @(posedge clk) begin
    if (rst)            PC <= '0;
    else if (br_take_i) PC <= br_target_i;
    else                PC <= PC + 32'd4;
  end

  assign pc_o    = PC;
  assign instr_o = instruction[PC[IW+1:2]];
endmodule

module decode (
  input  logic        clk,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] REG [32];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) REG[waddr_i] <= wdata_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : REG[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : REG[ra2_i];
endmodule

module memory #(
  parameter int unsigned DMEM_WORDS = 128
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(DMEM_WORDS)-1:0] addr_i,
  input  logic [31:0]                   wdata_i,
  output logic [31:0]                   rdata_o
);
  logic [31:0] DM [DMEM_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) DM[addr_i] <= wdata_i;
  end

  assign rdata_o = DM[addr_i];
endmodule

module mips_cpu #(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 128
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned DW = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dst;
    alu_op_e     alu;
    logic        use_imm;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_we;
    logic        beq;
    logic        bne;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] b;
    logic [31:0] target;
    logic [4:0]  dst;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_we;
    logic        take;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        reg_we;
  } mem_wb_t;

  logic [31:0] pc, instr, FD_PC, fd_ir_q;
  logic [31:0] rd1, rd2, dm_rdata, opb;
  id_ex_t      de_d, de_q;
  ex_mem_t     em_d, em_q;
  mem_wb_t     mw_d, mw_q;
  logic        unused_shamt;

  assign unused_shamt = ^fd_ir_q[10:6];

  fetch #(.IMEM_WORDS(IMEM_WORDS)) IF (
    .clk(clk), .rst(rst), .br_take_i(em_q.take), .br_target_i(em_q.target),
    .pc_o(pc), .instr_o(instr)
  );

  // Writes are suppressed during reset so in-flight stores/loads are discarded.
  decode ID (
    .clk(clk), .ra1_i(fd_ir_q[25:21]), .ra2_i(fd_ir_q[20:16]),
    .we_i(mw_q.reg_we && !rst), .waddr_i(mw_q.dst), .wdata_i(mw_q.data),
    .rd1_o(rd1), .rd2_o(rd2)
  );

  memory #(.DMEM_WORDS(DMEM_WORDS)) MEM (
    .clk(clk), .we_i(em_q.mem_we && !rst), .addr_i(em_q.alu[DW-1:0]),
    .wdata_i(em_q.b), .rdata_o(dm_rdata)
  );

  always_comb begin
    de_d     = '0;
    de_d.pc4 = FD_PC;
    de_d.a   = rd1;
    de_d.b   = rd2;
    de_d.imm = {{16{fd_ir_q[15]}}, fd_ir_q[15:0]};
    de_d.alu = ALU_ADD;
    case (fd_ir_q[31:26])
      6'h00: begin
        de_d.dst = fd_ir_q[15:11];
        case (fd_ir_q[5:0])
          6'h20: de_d.reg_we = 1'b1;
          6'h22: begin de_d.reg_we = 1'b1; de_d.alu = ALU_SUB; end
          6'h2A: begin de_d.reg_we = 1'b1; de_d.alu = ALU_SLT; end
          default: ;
        endcase
      end
      6'h23: begin
        de_d.dst     = fd_ir_q[20:16];
        de_d.use_imm = 1'b1;
        de_d.reg_we  = 1'b1;
        de_d.mem_rd  = 1'b1;
      end
      6'h2B: begin de_d.use_imm = 1'b1; de_d.mem_we = 1'b1; end
      6'h04: de_d.beq = 1'b1;
      6'h05: de_d.bne = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    em_d = '0;
    opb  = de_q.use_imm ? de_q.imm : de_q.b;
    case (de_q.alu)
      ALU_SUB: em_d.alu = de_q.a - opb;
      ALU_SLT: em_d.alu = {31'd0, $signed(de_q.a) < $signed(opb)};
      default: em_d.alu = de_q.a + opb;
    endcase
    em_d.b      = de_q.b;
    em_d.target = de_q.pc4 + {de_q.imm[29:0], 2'b00};
    em_d.dst    = de_q.dst;
    em_d.reg_we = de_q.reg_we;
    em_d.mem_rd = de_q.mem_rd;
    em_d.mem_we = de_q.mem_we;
    em_d.take   = (de_q.beq && (de_q.a == de_q.b)) || (de_q.bne && (de_q.a != de_q.b));
  end

  always_comb begin
    mw_d        = '0;
    mw_d.data   = em_q.mem_rd ? dm_rdata : em_q.alu;
    mw_d.dst    = em_q.dst;
    mw_d.reg_we = em_q.reg_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      FD_PC   <= '0;
      fd_ir_q <= '0;
      de_q    <= '0;
      em_q    <= '0;
      mw_q    <= '0;
    end else begin
      FD_PC   <= pc + 32'd4;
      fd_ir_q <= instr;
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
    end
  end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed programs checked each cycle against an instruction-level model
// (in-order execution, 3 branch delay slots, delayed architectural commit).

module tb_mips_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_cpu #(.IMEM_WORDS(128), .DMEM_WORDS(128)) dut (.clk(clk), .rst(rst));

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic [31:0] img_i [128];
  logic [31:0] img_r [32];
  logic [31:0] img_d [128];
  int          trace [128];

  typedef struct {
    int          due;
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } commit_t;

  commit_t     commits [$];
  logic [31:0] mreg [32];
  logic [31:0] mdm  [128];
  logic [31:0] creg [32];
  logic [31:0] cdm  [128];

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input int imm);
    logic [31:0] im;
    im = imm;
    return {op, rs, rt, im[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 128; i++) begin
      img_i[i] = NOP;
      img_d[i] = '0;
    end
    for (int i = 0; i < 32; i++) img_r[i] = '0;
  endtask

  task automatic load_dut();
    for (int i = 0; i < 128; i++) begin
      dut.IF.instruction[i] = img_i[i];
      dut.MEM.DM[i]         = img_d[i];
    end
    for (int i = 0; i < 32; i++) dut.ID.REG[i] = img_r[i];
  endtask

  task automatic model_exec(input int k, inout logic [31:0] mpc, inout int slots,
                            inout logic [31:0] btgt);
    logic [31:0] ir, a, b, simm, ea, res;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pcidx;
    pcidx = mpc >> 2;
    ir    = img_i[pcidx[6:0]];
    op    = ir[31:26];
    fn    = ir[5:0];
    rs    = ir[25:21];
    rt    = ir[20:16];
    rd    = ir[15:11];
    simm  = {{16{ir[15]}}, ir[15:0]};
    a     = mreg[rs];
    b     = mreg[rt];
    ea    = a + simm;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      if (fn == 6'h20)      res = a + b;
      else if (fn == 6'h22) res = a - b;
      else                  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (rd != 0) begin
        mreg[rd] = res;
        commits.push_back('{k + 5, 1'b0, int'(rd), res});
      end
    end else if (op == 6'h23) begin
      if (rt != 0) begin
        mreg[rt] = mdm[ea[6:0]];
        commits.push_back('{k + 5, 1'b0, int'(rt), mdm[ea[6:0]]});
      end
    end else if (op == 6'h2B) begin
      mdm[ea[6:0]] = b;
      commits.push_back('{k + 4, 1'b1, int'(ea[6:0]), b});
    end else if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) begin
      slots = 4;
      btgt  = mpc + 32'd4 + (simm << 2);
    end
    if (slots > 0) begin
      slots--;
      mpc = (slots == 0) ? btgt : mpc + 32'd4;
    end else begin
      mpc = mpc + 32'd4;
    end
  endtask

  task automatic run(input int ncyc);
    logic [31:0] mpc, btgt;
    int          slots, bad;
    mpc   = '0;
    btgt  = '0;
    slots = 0;
    commits.delete();
    for (int i = 0; i < 32; i++) begin mreg[i] = img_r[i]; creg[i] = img_r[i]; end
    for (int i = 0; i < 128; i++) begin mdm[i] = img_d[i]; cdm[i] = img_d[i]; trace[i] = -1; end
    rst = 1'b1;
    load_dut();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      for (int j = commits.size() - 1; j >= 0; j--) begin
        if (commits[j].due <= k) begin
          if (commits[j].is_mem) cdm[commits[j].idx]  = commits[j].val;
          else                   creg[commits[j].idx] = commits[j].val;
          commits.delete(j);
        end
      end
      if (k < 128) trace[k] = int'(dut.IF.PC);
      check($sformatf("pc@%0d", k), dut.IF.PC, mpc);
      bad = -1;
      for (int i = 31; i >= 0; i--) if (dut.ID.REG[i] !== creg[i]) bad = i;
      if (bad < 0) check($sformatf("regfile@%0d", k), 32'd0, 32'd0 + (dut.ID.REG[0] !== creg[0]));
      else         check($sformatf("reg%0d@%0d", bad, k), dut.ID.REG[bad], creg[bad]);
      bad = -1;
      for (int i = 127; i >= 0; i--) if (dut.MEM.DM[i] !== cdm[i]) bad = i;
      if (bad >= 0) check($sformatf("dm%0d@%0d", bad, k), dut.MEM.DM[bad], cdm[bad]);
      model_exec(k, mpc, slots, btgt);
    end
  endtask

  initial begin
    // Reset leaves preloaded storage untouched.
    clear_image();
    img_r[1] = 32'd1;
    img_d[0] = 32'd9;
    img_i[0] = 32'h1234_5678;
    rst = 1'b1;
    load_dut();
    @(posedge clk);
    #1;
    check("reset_pc", dut.IF.PC, 32'd0);
    check("reset_fd_pc", dut.FD_PC, 32'd0);
    check("reset_reg1", dut.ID.REG[1], 32'd1);
    check("reset_dm0", dut.MEM.DM[0], 32'd9);
    check("reset_imem0", dut.IF.instruction[0], 32'h1234_5678);

    // Load/store.
    clear_image();
    img_d[0] = 32'd9; img_d[1] = 32'd3;
    img_r[1] = 32'd1; img_r[2] = 32'd2;
    img_i[0] = itype(6'h23, 5'd0, 5'd3, 0);
    img_i[1] = itype(6'h23, 5'd1, 5'd4, 0);
    img_i[5] = itype(6'h2B, 5'd2, 5'd3, 0);
    run(15);
    check("ls_reg3", dut.ID.REG[3], 32'd9);
    check("ls_reg4", dut.ID.REG[4], 32'd3);
    check("ls_dm2", dut.MEM.DM[2], 32'd9);

    // ALU, signed slt, $0 write, untaken branch, unsupported opcode.
    clear_image();
    img_r[1] = 32'd1; img_r[2] = 32'd2; img_r[3] = 32'd9; img_r[4] = 32'd3;
    img_r[6] = 32'hFFFF_FFFF; img_r[7] = 32'd1;
    img_i[0]  = rtype(6'h22, 5'd3, 5'd4, 5'd3);
    img_i[4]  = rtype(6'h2A, 5'd4, 5'd3, 5'd5);
    img_i[8]  = rtype(6'h20, 5'd0, 5'd3, 5'd5);
    img_i[12] = rtype(6'h2A, 5'd6, 5'd7, 5'd9);
    img_i[13] = rtype(6'h2A, 5'd7, 5'd6, 5'd10);
    img_i[14] = rtype(6'h20, 5'd1, 5'd2, 5'd0);
    img_i[15] = itype(6'h04, 5'd3, 5'd4, 10);
    img_i[19] = rtype(6'h20, 5'd3, 5'd3, 5'd11);
    img_i[20] = itype(6'h08, 5'd0, 5'd12, 5);
    run(30);
    check("alu_sub_reg3", dut.ID.REG[3], 32'd6);
    check("alu_add_reg5", dut.ID.REG[5], 32'd6);
    check("alu_slt_neg", dut.ID.REG[9], 32'd1);
    check("alu_slt_pos", dut.ID.REG[10], 32'd0);
    check("alu_reg0", dut.ID.REG[0], 32'd0);
    check("untaken_seq", dut.ID.REG[11], 32'd12);
    check("unsupported", dut.ID.REG[12], 32'd0);
    check("slt_trace_pc9", trace[9], 32'd36);

    // GCD(9,3) by repeated subtraction.
    clear_image();
    img_d[0] = 32'd9; img_d[1] = 32'd3;
    img_r[1] = 32'd1; img_r[2] = 32'd2;
    img_i[0]  = itype(6'h23, 5'd0, 5'd3, 0);
    img_i[1]  = itype(6'h23, 5'd1, 5'd4, 0);
    img_i[5]  = itype(6'h04, 5'd3, 5'd4, 35);
    img_i[9]  = rtype(6'h2A, 5'd4, 5'd3, 5'd5);
    img_i[13] = itype(6'h05, 5'd5, 5'd0, 19);
    img_i[17] = rtype(6'h22, 5'd4, 5'd3, 5'd4);
    img_i[18] = itype(6'h05, 5'd1, 5'd2, -14);
    img_i[33] = rtype(6'h22, 5'd3, 5'd4, 5'd3);
    img_i[37] = itype(6'h05, 5'd1, 5'd2, -33);
    img_i[41] = itype(6'h2B, 5'd2, 5'd3, 0);
    run(66);
    check("gcd_dm2", dut.MEM.DM[2], 32'd3);
    check("gcd_reg3", dut.ID.REG[3], 32'd3);
    check("gcd_reg4", dut.ID.REG[4], 32'd3);
    check("bne_taken_pc", trace[17], 32'd132);
    check("bne_back_pc", trace[25], 32'd20);
    check("beq_taken_pc", trace[49], 32'd164);

    // Reset mid-operation restarts fetch at 0.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pc", dut.IF.PC, 32'd0);
    check("midrst_fd_pc", dut.FD_PC, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_pc_next", dut.IF.PC, 32'd4);
    check("midrst_dm2", dut.MEM.DM[2], 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
